mips_muldiv: RTL
================

Name: mips_muldiv

Overview:
Iterative multiply/divide unit owning the MIPS HI/LO registers. It consumes the two register-file read operands (a = rs, b = rt) and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. The result is held in HI/LO for MFHI/MFLO. It sits beside the ALU in the execute stage, and the control unit stalls on its busy output.

Parameters:
WIDTH, 32, operand/HI/LO width; only 32 is verified
CNT_BITS, 5, iteration counter width; must satisfy 2**CNT_BITS == WIDTH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  request present this cycle
op  input  3  operation code (muldiv_pkg::muldiv_op_t)
a  input  WIDTH  operand from rs (dividend / multiplicand / MTHI-MTLO source)
b  input  WIDTH  operand from rt (divisor / multiplier)
op_ready  output  1  high when a request will be accepted (= !busy)
busy  output  1  iterative operation in progress
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset is asynchronous: state=IDLE, counter=0, hi=0, lo=0, busy=0. Any in-flight operation is discarded with no HI/LO write.
- op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, 7 reserved (treated as NONE).
- A request is accepted on a rising edge with op_valid && op_ready && op!=NONE. a and b are sampled only at acceptance; later operand changes are ignored.
- If op_valid is high while busy, the request is ignored (not queued). Upstream holds it until op_ready.
- MTHI/MTLO: hi<=a (or lo<=a) at the accepting edge. Stays IDLE, busy never asserts.
- States:
  - IDLE -> RUN on accepting MULT/MULTU/DIV/DIVU.
  - RUN: one iteration per cycle for WIDTH cycles; counter 0..WIDTH-1. counter==WIDTH-1 -> FIX.
  - FIX: sign correction, write hi/lo -> IDLE.
- busy = (state != IDLE). It is high for exactly WIDTH+1 = 33 cycles after the accept edge. The new hi/lo values are visible in the first cycle busy is low.
- hi/lo hold their old values throughout RUN. They update only in FIX (or at MTHI/MTLO).
- Signed ops: on acceptance, latch magnitudes |a|, |b| plus sign flags.
  - MULT: product negated in FIX if sign(a)^sign(b).
  - DIV: quotient negated if sign(a)^sign(b); remainder takes the sign of a.
- Multiply: shift-add over a 2*WIDTH accumulator. hi = upper word, lo = lower word.
- Divide: restoring shift-subtract. lo = quotient, hi = remainder.
- Divide by zero (b==0, DIV or DIVU): lo=0xFFFFFFFF, hi=a (raw operand), same 33-cycle timing.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (magnitude arithmetic wrap, no trap).
- All arithmetic is modulo 2**WIDTH per word. No overflow flags.

Decomposition:
- Package muldiv_pkg: muldiv_op_t enum (3-bit), state_t enum {IDLE, RUN, FIX}, constant DIV0_QUOTIENT = 32'hFFFFFFFF.
- One sub-module, muldiv_iter: single-step datapath (one shift-add or shift-subtract step on {acc, operand}, selected by a mode bit).
- The top holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 33 cycles, then hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- DIVU 100/7 accepted; at cycle 5 assert op_valid MTHI a=0x1234 -> ignored, op_ready=0. After busy falls: lo=14 hi=2. Then MTHI a=0x1234 -> hi=0x1234 next cycle, busy stays 0.
- Operand hold: MULTU 3*4 accepted; change a,b every cycle during RUN -> hi=0 lo=12.
- MULTU in flight with hi=0xAA lo=0xBB preset via MTHI/MTLO; assert reset asynchronously (mid-clock) at cycle 10 -> hi=lo=0 and busy=0 immediately, before the next edge. After release, DIVU 9/3 -> lo=3 hi=0.

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes, FSM states
// and the fixed quotient returned on divide-by-zero.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface mips_muldiv_if #(
   parameter int WIDTH = 32
);
   import muldiv_pkg::*;

   logic             op_valid;
   muldiv_op_t       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_ready;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output op_valid, op, a, b,
      input  op_ready, busy, hi, lo
   );

   modport slave (
      input  op_valid, op, a, b,
      output op_ready, busy, hi, lo
   );

endinterface

// File: rtl/mips_muldiv_iter.sv
// One iteration of the unsigned datapath on {acc, opnd}: a right-shifting
// shift-add for multiply, or a left-shifting restoring subtract for divide.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             div_mode,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] opnd_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] opnd_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] diff;
   logic             ge;

   always_comb begin
      sum    = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, m_i} : {(WIDTH+1){1'b0}});
      rem_sh = {acc_i, opnd_i[WIDTH-1]};
      ge     = (rem_sh >= {1'b0, m_i});
      // remainder stays below the divisor, so the true difference fits one word
      diff   = rem_sh[WIDTH-1:0] - m_i;

      acc_o  = acc_i;
      opnd_o = opnd_i;
      if (div_mode) begin
         acc_o  = ge ? diff : rem_sh[WIDTH-1:0];
         opnd_o = {opnd_i[WIDTH-2:0], ge};
      end else begin
         acc_o  = sum[WIDTH:1];
         opnd_o = {sum[0], opnd_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO. Signed operations run on
// magnitudes and are sign-corrected in a single FIX cycle.
module mips_muldiv
   import muldiv_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int CNT_BITS = 5
) (
   input logic          clk,
   input logic          reset,
   mips_muldiv_if.slave bus
);

   state_t                state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]      hi_q, hi_d;
   logic [WIDTH-1:0]      lo_q, lo_d;
   logic [WIDTH-1:0]      acc_q, acc_d;
   logic [WIDTH-1:0]      opnd_q, opnd_d;
   logic [WIDTH-1:0]      m_q, m_d;
   logic [WIDTH-1:0]      raw_a_q, raw_a_d;
   logic                  div_q, div_d;
   logic                  neg_q, neg_d;
   logic                  sa_q, sa_d;
   logic                  div0_q, div0_d;

   logic [WIDTH-1:0]      iter_acc;
   logic [WIDTH-1:0]      iter_opnd;
   logic                  is_signed;
   logic                  sign_a;
   logic                  sign_b;
   logic [2*WIDTH-1:0]    prod;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .div_mode (div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .m_i      (m_q),
      .acc_o    (iter_acc),
      .opnd_o   (iter_opnd)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      m_d       = m_q;
      raw_a_d   = raw_a_q;
      div_d     = div_q;
      neg_d     = neg_q;
      sa_d      = sa_q;
      div0_d    = div0_q;
      is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
      sign_a    = is_signed && bus.a[WIDTH-1];
      sign_b    = is_signed && bus.b[WIDTH-1];
      prod      = {acc_q, opnd_q};

      case (state_q)
         IDLE: begin
            if (bus.op_valid) begin
               case (bus.op)
                  OP_MTHI: hi_d = bus.a;
                  OP_MTLO: lo_d = bus.a;
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     state_d = RUN;
                     cnt_d   = '0;
                     acc_d   = '0;
                     opnd_d  = sign_a ? -bus.a : bus.a;
                     m_d     = sign_b ? -bus.b : bus.b;
                     raw_a_d = bus.a;
                     div_d   = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
                     neg_d   = sign_a ^ sign_b;
                     sa_d    = sign_a;
                     div0_d  = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) && (bus.b == '0);
                  end
                  default: ;
               endcase
            end
         end
         RUN: begin
            acc_d  = iter_acc;
            opnd_d = iter_opnd;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_BITS'(WIDTH-1))
               state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
            if (div0_q) begin
               hi_d = raw_a_q;
               lo_d = DIV0_QUOTIENT;
            end else if (div_q) begin
               // quotient sign from both operands, remainder follows the dividend
               lo_d = neg_q ? -opnd_q : opnd_q;
               hi_d = sa_q ? -acc_q : acc_q;
            end else begin
               if (neg_q)
                  prod = -{acc_q, opnd_q};
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         m_q     <= '0;
         raw_a_q <= '0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         sa_q    <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         m_q     <= m_d;
         raw_a_q <= raw_a_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         sa_q    <= sa_d;
         div0_q  <= div0_d;
      end
   end

   assign bus.busy     = (state_q != IDLE);
   assign bus.op_ready = (state_q == IDLE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule
